// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: ALU results take the single write port first,
// load returns wait in an in-order queue and drain on ALU-free cycles.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_dest,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_dest,
  input  logic [DW-1:0]            ld_data,
  input  logic [AW-1:0]            q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   ld_count,
  output logic                     RW,
  output logic [AW-1:0]            DA,
  output logic [DW-1:0]            writeData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    dest_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;

  logic alu_wr, pop, push, push_live, head_wr;

  always_comb begin
    alu_wr    = alu_valid && (alu_dest != '0);
    ld_ready  = reset && (count < CW'(DEPTH));
    pop       = !alu_wr && (count != '0);
    head_wr   = pop && live_q[head];
    // r0 loads are accepted but never occupy a slot
    push      = ld_valid && ld_ready && (ld_dest != '0);
    // a same-cycle load to the ALU's register is older, so it arrives already dead
    push_live = !(alu_wr && (alu_dest == ld_dest));
  end

  always_comb begin
    q_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (dest_q[i] == q_addr)) q_pending = 1'b1;
    end
    if (q_addr == '0) q_pending = 1'b0;
  end

  assign ld_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[tail] <= ld_dest;
      data_q[tail] <= ld_data;
    end
  end

  // queue control and registered write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      live_q    <= '0;
      RW        <= 1'b0;
      DA        <= '0;
      writeData <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_wr && (dest_q[i] == alu_dest)) live_q[i] <= 1'b0;
      end
      // popped slots are cleared so live alone marks a stored, pending entry
      if (pop) begin
        live_q[head] <= 1'b0;
        head         <= head + PW'(1);
      end
      if (push) begin
        live_q[tail] <= push_live;
        tail         <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      RW    <= alu_wr || head_wr;
      if (alu_wr) begin
        DA        <= alu_dest;
        writeData <= alu_data;
      end else if (head_wr) begin
        DA        <= dest_q[head];
        writeData <= data_q[head];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: expected writes are queued as stimulus
// is driven and retired in order whenever the write port fires.
module tb_regfile_writeback;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   alu_valid;
  logic [AW-1:0]          alu_dest;
  logic [DW-1:0]          alu_data;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [AW-1:0]          ld_dest;
  logic [DW-1:0]          ld_data;
  logic [AW-1:0]          q_addr;
  logic                   q_pending;
  logic [$clog2(DEPTH):0] ld_count;
  logic                   RW;
  logic [AW-1:0]          DA;
  logic [DW-1:0]          writeData;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .q_addr(q_addr), .q_pending(q_pending), .ld_count(ld_count),
    .RW(RW), .DA(DA), .writeData(writeData)
  );

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wb(input logic [AW-1:0] d, input logic [DW-1:0] v);
    wb_t e;
    e.dest = d;
    e.data = v;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    check("r0_write", 64'(RW && (DA == '0)), 64'd0);
    if (RW) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 64'(RW), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_dest", 64'(DA), 64'(mon_e.dest));
        check("wb_data", 64'(writeData), 64'(mon_e.data));
      end
    end
  end

  initial begin
    reset = 1'b0; alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    ld_valid = 1'b0; ld_dest = '0; ld_data = '0; q_addr = 5'd5;
    tick(); tick();
    check("rst_rw", 64'(RW), 64'd0);
    check("rst_da", 64'(DA), 64'd0);
    check("rst_wd", 64'(writeData), 64'd0);
    check("rst_cnt", 64'(ld_count), 64'd0);
    check("rst_ready", 64'(ld_ready), 64'd0);
    check("rst_pending", 64'(q_pending), 64'd0);
    reset = 1'b1;
    #1 check("ready_after_rst", 64'(ld_ready), 64'd1);

    // single ALU write, latency 1
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hA5A5A5A5;
    expect_wb(5'd5, 32'hA5A5A5A5);
    tick();
    alu_valid = 1'b0;
    check("alu_lat_rw", 64'(RW), 64'd1);
    check("alu_lat_da", 64'(DA), 64'd5);
    tick();
    check("alu_rw_drop", 64'(RW), 64'd0);

    // three back-to-back loads, latency 2, in order
    ld_valid = 1'b1; ld_dest = 5'd3; ld_data = 32'h11; expect_wb(5'd3, 32'h11);
    tick();
    check("ld_stored_rw", 64'(RW), 64'd0);
    check("ld_cnt1", 64'(ld_count), 64'd1);
    ld_dest = 5'd4; ld_data = 32'h22; expect_wb(5'd4, 32'h22);
    tick();
    check("ld_lat2_rw", 64'(RW), 64'd1);
    check("ld_lat2_da", 64'(DA), 64'd3);
    ld_dest = 5'd6; ld_data = 32'h33; expect_wb(5'd6, 32'h33);
    tick();
    ld_valid = 1'b0;
    check("ld2_da", 64'(DA), 64'd4);
    tick();
    check("ld3_da", 64'(DA), 64'd6);
    check("ld_cnt0", 64'(ld_count), 64'd0);

    // fill under continuous ALU traffic, then drain
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h70000000 + 32'(i);
      expect_wb(5'd7, 32'h70000000 + 32'(i));
      ld_valid = 1'b1; ld_dest = AW'(11 + i); ld_data = 32'hB0 + 32'(i);
      check("fill_ready", 64'(ld_ready), 64'd1);
      tick();
    end
    ld_valid = 1'b0;
    check("full_ready", 64'(ld_ready), 64'd0);
    check("full_cnt", 64'(ld_count), 64'd4);
    for (int i = 4; i < 6; i++) begin
      alu_data = 32'h70000000 + 32'(i);
      expect_wb(5'd7, 32'h70000000 + 32'(i));
      tick();
      check("full_hold", 64'(ld_ready), 64'd0);
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) expect_wb(AW'(11 + i), 32'hB0 + 32'(i));
    repeat (4) tick();
    check("drain_cnt", 64'(ld_count), 64'd0);
    check("drain_ready", 64'(ld_ready), 64'd1);

    // younger ALU write kills a queued load
    q_addr = 5'd10;
    ld_valid = 1'b1; ld_dest = 5'd10; ld_data = 32'h5A5A5A5A;
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h99;
    expect_wb(5'd9, 32'h99);
    tick();
    ld_valid = 1'b0;
    check("kill_pend1", 64'(q_pending), 64'd1);
    alu_dest = 5'd10; alu_data = 32'hFFFF0000;
    expect_wb(5'd10, 32'hFFFF0000);
    tick();
    alu_valid = 1'b0;
    check("kill_pend0", 64'(q_pending), 64'd0);
    check("kill_cnt", 64'(ld_count), 64'd1);
    tick();
    check("kill_pop_rw", 64'(RW), 64'd0);
    check("kill_pop_cnt", 64'(ld_count), 64'd0);

    // same-cycle load to the ALU's register is enqueued dead
    q_addr = 5'd12;
    ld_valid = 1'b1; ld_dest = 5'd12; ld_data = 32'hDEAD;
    alu_valid = 1'b1; alu_dest = 5'd12; alu_data = 32'hC;
    expect_wb(5'd12, 32'hC);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    check("same_pend", 64'(q_pending), 64'd0);
    check("same_cnt", 64'(ld_count), 64'd1);
    tick();
    check("same_pop_rw", 64'(RW), 64'd0);

    // register 0 traffic from both sources
    alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'hFFFFFFFF;
    ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'h1234;
    check("r0_ready", 64'(ld_ready), 64'd1);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    check("r0_rw", 64'(RW), 64'd0);
    check("r0_cnt", 64'(ld_count), 64'd0);

    // ALU to r0 does not block a pop
    ld_valid = 1'b1; ld_dest = 5'd2; ld_data = 32'h2; expect_wb(5'd2, 32'h2);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b1; alu_dest = 5'd0;
    tick();
    alu_valid = 1'b0;
    check("r0alu_pop_rw", 64'(RW), 64'd1);

    // reset with entries queued
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h7700 + 32'(i);
      expect_wb(5'd7, 32'h7700 + 32'(i));
      ld_valid = 1'b1; ld_dest = AW'(20 + i); ld_data = 32'hE0 + 32'(i);
      tick();
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    check("pre_rst_cnt", 64'(ld_count), 64'd3);
    reset = 1'b0;
    #1 check("rdy_in_rst", 64'(ld_ready), 64'd0);
    tick();
    check("mid_rst_rw", 64'(RW), 64'd0);
    check("mid_rst_cnt", 64'(ld_count), 64'd0);
    check("mid_rst_ready", 64'(ld_ready), 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", 64'(ld_ready), 64'd1);
    repeat (4) tick();
    check("no_stale_rw", 64'(RW), 64'd0);

    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
